// File: rtl/board_reset_ctrl.sv
// Board reset sequencer: stretches POR, debounces the user button and accepts
// a software reset request, holding soc_reset and recording the last cause.
module board_reset_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 1024,
    parameter int CNT_W           = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_n,
    input  logic       sw_req,
    output logic       soc_reset,
    output logic [1:0] cause,
    output logic [7:0] reset_count,
    output logic       key_level
);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PRESS = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_KEY = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             key_meta_q, key_meta_d;
    logic             key_sync_q, key_sync_d;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [1:0]       cause_q, cause_d;
    logic [7:0]       rcnt_q, rcnt_d;
    logic             soc_reset_q, soc_reset_d;
    logic             count_inc;

    // Two-flop synchronizer; idles at 1 so reset looks like a released button.
    always_comb begin
        key_meta_d = key_n;
        key_sync_d = key_meta_q;
    end

    always_comb begin
        deb_d  = deb_q;
        dcnt_d = dcnt_q;
        if (key_sync_q == deb_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DEB_LAST) begin
            deb_d  = key_sync_q;
            dcnt_d = '0;
        end else begin
            dcnt_d = dcnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            deb_q      <= 1'b1;
            dcnt_q     <= '0;
        end else begin
            key_meta_q <= key_meta_d;
            key_sync_q <= key_sync_d;
            deb_q      <= deb_d;
            dcnt_q     <= dcnt_d;
        end
    end

    // A debounced press wins over a simultaneous software request.
    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        cause_d   = cause_q;
        rcnt_d    = rcnt_q;
        count_inc = 1'b0;

        case (state_q)
            ST_HOLD: begin
                if (hcnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    hcnt_d  = '0;
                end else begin
                    hcnt_d = hcnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (!deb_q) begin
                    state_d   = ST_PRESS;
                    cause_d   = CAUSE_KEY;
                    count_inc = 1'b1;
                end else if (sw_req) begin
                    state_d   = ST_HOLD;
                    hcnt_d    = '0;
                    cause_d   = CAUSE_SW;
                    count_inc = 1'b1;
                end
            end
            ST_PRESS: begin
                if (deb_q) begin
                    state_d = ST_HOLD;
                    hcnt_d  = '0;
                end
            end
            default: begin
                state_d = ST_HOLD;
                hcnt_d  = '0;
            end
        endcase

        if (count_inc && (rcnt_q != 8'hFF)) begin
            rcnt_d = rcnt_q + 8'd1;
        end

        soc_reset_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_HOLD;
            hcnt_q      <= '0;
            cause_q     <= CAUSE_POR;
            rcnt_q      <= 8'd0;
            soc_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            cause_q     <= cause_d;
            rcnt_q      <= rcnt_d;
            soc_reset_q <= soc_reset_d;
        end
    end

    assign soc_reset   = soc_reset_q;
    assign cause       = cause_q;
    assign reset_count = rcnt_q;
    assign key_level   = ~deb_q;

endmodule

// File: tb/tb_board_reset_ctrl.sv
// Scoreboard bench for board_reset_ctrl: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the registered outputs.
`timescale 1ns/1ps
module tb_board_reset_ctrl;

    localparam int DEB  = 4;
    localparam int HOLD = 8;

    logic       clock  = 1'b0;
    logic       reset  = 1'b1;
    logic       key_n  = 1'b1;
    logic       sw_req = 1'b0;
    logic       soc_reset;
    logic [1:0] cause;
    logic [7:0] reset_count;
    logic       key_level;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic       soc;
        logic [1:0] cs;
        logic [7:0] cnt;
        logic       kl;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    board_reset_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES(HOLD),
        .CNT_W(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .key_n(key_n),
        .sw_req(sw_req),
        .soc_reset(soc_reset),
        .cause(cause),
        .reset_count(reset_count),
        .key_level(key_level)
    );

    always #50 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic pushAt(input int at, input logic soc, input logic [1:0] cs,
                          input logic [7:0] cnt, input logic kl, input string name);
        exp_t e;
        e.cyc  = at;
        e.soc  = soc;
        e.cs   = cs;
        e.cnt  = cnt;
        e.kl   = kl;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic key, input logic sw, input int n);
        key_n  = key;
        sw_req = sw;
        repeat (n) @(negedge clock);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (e.cyc != cyc) begin
            errors++;
            $display("[TB] FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
        end else if (soc_reset !== e.soc || cause !== e.cs || reset_count !== e.cnt || key_level !== e.kl) begin
            errors++;
            $display("[TB] FAIL %s @%0d: got soc_reset=%b cause=%b reset_count=%0d key_level=%b, expected soc_reset=%b cause=%b reset_count=%0d key_level=%b",
                     e.name, cyc, soc_reset, cause, reset_count, key_level, e.soc, e.cs, e.cnt, e.kl);
        end
    endtask

    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            checkOutput(cur);
        end
    end

    initial begin
        #5_000_000;
        errors++;
        $display("[TB] FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int c;

        // Power-on reset held three cycles, then released with the key up.
        applyStimulus(1'b1, 1'b0, 1);
        pushAt(cyc + 1, 1'b1, 2'd0, 8'd0, 1'b0, "por_in_reset");
        applyStimulus(1'b1, 1'b0, 2);
        reset = 1'b0;
        c = cyc;
        for (int e = 1; e <= 7; e++) pushAt(c + e, 1'b1, 2'd0, 8'd0, 1'b0, "por_hold");
        pushAt(c + 8, 1'b0, 2'd0, 8'd0, 1'b0, "por_run");
        applyStimulus(1'b1, 1'b0, 10);

        // Key press held 12 cycles, then released.
        c = cyc;
        for (int e = 1; e <= 12; e++)
            pushAt(c + e, (e >= 7), (e >= 7) ? 2'd1 : 2'd0, (e >= 7) ? 8'd1 : 8'd0, (e >= 6), "key_press");
        applyStimulus(1'b0, 1'b0, 12);
        c = cyc;
        for (int e = 1; e <= 15; e++)
            pushAt(c + e, (e < 15), 2'd1, 8'd1, (e < 6), "key_release");
        applyStimulus(1'b1, 1'b0, 17);

        // Bouncing key: runs of three samples never reach the debounce count.
        c = cyc;
        for (int e = 1; e <= 48; e++) pushAt(c + e, 1'b0, 2'd1, 8'd1, 1'b0, "bounce");
        for (int i = 0; i < 40; i++) applyStimulus((((i / 3) % 2) == 0) ? 1'b0 : 1'b1, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 8);

        // Software reset plus ignored requests while holding.
        c = cyc;
        for (int e = 1; e <= 8; e++) pushAt(c + e, 1'b1, 2'd2, 8'd2, 1'b0, "sw_hold");
        pushAt(c + 9, 1'b0, 2'd2, 8'd2, 1'b0, "sw_run");
        pushAt(c + 12, 1'b0, 2'd2, 8'd2, 1'b0, "sw_run_later");
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 6);

        // Debounced press and sw_req sampled on the same edge.
        c = cyc;
        for (int e = 1; e <= 6; e++) pushAt(c + e, 1'b0, 2'd2, 8'd2, (e >= 6), "simul_pre");
        for (int e = 7; e <= 18; e++) pushAt(c + e, 1'b1, 2'd1, 8'd3, 1'b1, "simul_press");
        applyStimulus(1'b0, 1'b0, 6);
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 11);
        c = cyc;
        for (int e = 1; e <= 15; e++)
            pushAt(c + e, (e < 15), 2'd1, 8'd3, (e < 6), "simul_release");
        applyStimulus(1'b1, 1'b0, 17);

        // 260 software resets; the count must stop at 255.
        for (int i = 1; i <= 260; i++) begin
            c = cyc;
            pushAt(c + 9, 1'b0, 2'd2, ((3 + i) > 255) ? 8'd255 : 8'(3 + i), 1'b0, "saturate");
            applyStimulus(1'b1, 1'b1, 1);
            applyStimulus(1'b1, 1'b0, 9);
        end

        // Asynchronous reset while the button is held in PRESS.
        c = cyc;
        for (int e = 1; e <= 6; e++) pushAt(c + e, 1'b0, 2'd2, 8'd255, (e >= 6), "pre_press");
        for (int e = 7; e <= 10; e++) pushAt(c + e, 1'b1, 2'd1, 8'd255, 1'b1, "sat_press");
        applyStimulus(1'b0, 1'b0, 10);
        @(posedge clock);
        #10;
        reset = 1'b1;
        pushAt(cyc, 1'b1, 2'd0, 8'd0, 1'b0, "async_reset");
        @(negedge clock);
        pushAt(cyc + 1, 1'b1, 2'd0, 8'd0, 1'b0, "reset_held");
        applyStimulus(1'b0, 1'b0, 1);
        reset = 1'b0;
        c = cyc;
        for (int e = 1; e <= 7; e++) pushAt(c + e, 1'b1, 2'd0, 8'd0, (e >= 6), "rehold");
        pushAt(c + 8, 1'b0, 2'd0, 8'd0, 1'b1, "rehold_run");
        for (int e = 9; e <= 14; e++) pushAt(c + e, 1'b1, 2'd1, 8'd1, 1'b1, "repress");
        applyStimulus(1'b0, 1'b0, 16);
        applyStimulus(1'b1, 1'b0, 2);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries pending, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
